// File: rtl/ctrl_sequencer.sv
// Eight-phase instruction sequencer for the accumulator CPU: drives address-mux select and datapath strobes.
// Latency: outputs are a zero-latency combinational decode of the phase register, opcode and zero.
// Backpressure: none by default; with CTRL_STALL_EN, stall holds the phase and suppresses state-changing strobes.
//
// Optional feature macro: CTRL_STALL_EN (adds the `stall` input).
//
// Ports:
//   clk, rst      - rising-edge clock, asynchronous active-high reset
//   opcode, zero  - current instruction opcode from IR, accumulator-is-zero flag
//   stall         - (CTRL_STALL_EN only) freeze phase, gate strobes
//   sel           - address mux select, SEL_ACTIVE selects the PC address
//   mem_rd/mem_wr - memory read enable / write strobe
//   load_ir/load_ac/load_pc/inc_pc - register load and PC increment strobes
//   data_e        - accumulator drives data bus
//   halt          - CPU halted (sticky until rst)
//   phase         - current phase, for debug
module ctrl_sequencer #(
   parameter logic SEL_ACTIVE = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] opcode,
   input  logic       zero,
`ifdef CTRL_STALL_EN
   input  logic       stall,
`endif
   output logic       sel,
   output logic       mem_rd,
   output logic       mem_wr,
   output logic       load_ir,
   output logic       load_ac,
   output logic       load_pc,
   output logic       inc_pc,
   output logic       data_e,
   output logic       halt,
   output logic [2:0] phase
);

   localparam logic [2:0] PH_INST_ADDR  = 3'd0;
   localparam logic [2:0] PH_INST_FETCH = 3'd1;
   localparam logic [2:0] PH_INST_LOAD  = 3'd2;
   localparam logic [2:0] PH_IDLE       = 3'd3;
   localparam logic [2:0] PH_OP_ADDR    = 3'd4;
   localparam logic [2:0] PH_OP_FETCH   = 3'd5;
   localparam logic [2:0] PH_ALU_OP     = 3'd6;
   localparam logic [2:0] PH_STORE      = 3'd7;

   localparam logic [2:0] OP_HLT = 3'd0;
   localparam logic [2:0] OP_SKZ = 3'd1;
   localparam logic [2:0] OP_ADD = 3'd2;
   localparam logic [2:0] OP_AND = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;
   localparam logic [2:0] OP_LDA = 3'd5;
   localparam logic [2:0] OP_STO = 3'd6;
   localparam logic [2:0] OP_JMP = 3'd7;

   logic halted;
   logic advance;
   logic alu_op;

`ifdef CTRL_STALL_EN
   assign advance = ~stall;
`else
   assign advance = 1'b1;
`endif

   assign alu_op = (opcode == OP_ADD) || (opcode == OP_AND) ||
                   (opcode == OP_XOR) || (opcode == OP_LDA);

   // Phase counter; a HLT seen in OP_ADDR parks the counter at OP_ADDR
   // instead of advancing, and only rst releases it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase  <= PH_INST_ADDR;
         halted <= 1'b0;
      end else if (!halted && advance) begin
         if (phase == PH_OP_ADDR && opcode == OP_HLT)
            halted <= 1'b1;
         else
            phase <= phase + 3'd1;
      end
   end

   always_comb begin
      sel     = ~SEL_ACTIVE;
      mem_rd  = 1'b0;
      mem_wr  = 1'b0;
      load_ir = 1'b0;
      load_ac = 1'b0;
      load_pc = 1'b0;
      inc_pc  = 1'b0;
      data_e  = 1'b0;
      halt    = 1'b0;
      case (phase)
         PH_INST_ADDR: begin
            sel = SEL_ACTIVE;
         end
         PH_INST_FETCH: begin
            sel    = SEL_ACTIVE;
            mem_rd = 1'b1;
         end
         PH_INST_LOAD, PH_IDLE: begin
            sel     = SEL_ACTIVE;
            mem_rd  = 1'b1;
            load_ir = 1'b1;
         end
         PH_OP_ADDR: begin
            inc_pc = 1'b1;
            halt   = (opcode == OP_HLT);
         end
         PH_OP_FETCH: begin
            mem_rd = alu_op;
         end
         PH_ALU_OP: begin
            mem_rd  = alu_op;
            inc_pc  = (opcode == OP_SKZ) && zero;
            load_pc = (opcode == OP_JMP);
            data_e  = (opcode == OP_STO);
         end
         PH_STORE: begin
            mem_rd  = alu_op;
            load_ac = alu_op;
            load_pc = (opcode == OP_JMP);
            // PC gives load_pc priority, so inc_pc here is harmless for JMP.
            inc_pc  = (opcode == OP_JMP);
            mem_wr  = (opcode == OP_STO);
            data_e  = (opcode == OP_STO);
         end
         default: begin
         end
      endcase

      // Parked in OP_ADDR: only halt remains, the phase-4 PC increment
      // must not keep firing.
      if (halted) begin
         sel     = ~SEL_ACTIVE;
         mem_rd  = 1'b0;
         mem_wr  = 1'b0;
         load_ir = 1'b0;
         load_ac = 1'b0;
         load_pc = 1'b0;
         inc_pc  = 1'b0;
         data_e  = 1'b0;
         halt    = 1'b1;
      end

`ifdef CTRL_STALL_EN
      // A stalled phase repeats, so anything that changes architectural
      // state is suppressed; read-side signals keep their decode.
      if (stall) begin
         mem_wr  = 1'b0;
         load_ir = 1'b0;
         load_ac = 1'b0;
         load_pc = 1'b0;
         inc_pc  = 1'b0;
      end
`endif
   end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed bench for ctrl_sequencer with hand-computed per-phase output masks.
// Output vector order: {sel, mem_rd, mem_wr, load_ir, load_ac, load_pc, inc_pc, data_e, halt}.
module tb_ctrl_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] opcode;
   logic       zero;
`ifdef CTRL_STALL_EN
   logic       stall;
`endif
   logic       sel, mem_rd, mem_wr, load_ir, load_ac, load_pc, inc_pc, data_e, halt;
   logic [2:0] phase;

   int n_checks = 0;
   int n_errors = 0;

   ctrl_sequencer #(.SEL_ACTIVE(1'b1)) dut (
      .clk     (clk),
      .rst     (rst),
      .opcode  (opcode),
      .zero    (zero),
`ifdef CTRL_STALL_EN
      .stall   (stall),
`endif
      .sel     (sel),
      .mem_rd  (mem_rd),
      .mem_wr  (mem_wr),
      .load_ir (load_ir),
      .load_ac (load_ac),
      .load_pc (load_pc),
      .inc_pc  (inc_pc),
      .data_e  (data_e),
      .halt    (halt),
      .phase   (phase)
   );

   always #5 clk = ~clk;

   function automatic logic [8:0] outs();
      return {sel, mem_rd, mem_wr, load_ir, load_ac, load_pc, inc_pc, data_e, halt};
   endfunction

   task automatic chk(input string tag, input logic [8:0] got, input logic [8:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%b exp=%b", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Advance to phase 0 within one full rotation.
   task automatic goto0();
      for (int i = 0; i < 8; i++) begin
         if (phase == 3'd0) break;
         step();
      end
      chk("align_phase0", {6'd0, phase}, 9'd0);
   endtask

   // One full instruction: checks phase and all outputs in each of 8 phases.
   // Masks hold one bit per phase (bit p = value in phase p).
   task automatic run_seq(input string tag, input logic [2:0] op, input logic z,
                          input logic [7:0] rd, input logic [7:0] wr, input logic [7:0] ir,
                          input logic [7:0] ac, input logic [7:0] pc, input logic [7:0] inc,
                          input logic [7:0] de);
      logic [7:0] sl;
      sl = 8'h0F;
      opcode = op;
      zero   = z;
      #1;
      for (int p = 0; p < 8; p++) begin
         chk($sformatf("%s_phase%0d", tag, p), {6'd0, phase}, p[8:0]);
         chk($sformatf("%s_outs_ph%0d", tag, p), outs(),
             {sl[p], rd[p], wr[p], ir[p], ac[p], pc[p], inc[p], de[p], 1'b0});
         step();
      end
   endtask

   initial begin
      rst    = 1'b1;
      opcode = 3'd2;
      zero   = 1'b0;
`ifdef CTRL_STALL_EN
      stall  = 1'b0;
`endif
      step();
      step();
      chk("reset_phase", {6'd0, phase}, 9'd0);
      chk("reset_outs", outs(), 9'b1_0000_0000);
      rst = 1'b0;
      step();
      chk("post_reset_phase1", {6'd0, phase}, 9'd1);

      // Asynchronous reset mid-phase 5.
      for (int i = 0; i < 4; i++) step();
      chk("pre_async_phase5", {6'd0, phase}, 9'd5);
      #3;
      rst = 1'b1;
      #1;
      chk("async_rst_phase", {6'd0, phase}, 9'd0);
      chk("async_rst_outs", outs(), 9'b1_0000_0000);
      step();
      chk("held_rst_phase", {6'd0, phase}, 9'd0);
      rst = 1'b0;
      step();
      chk("release_phase1", {6'd0, phase}, 9'd1);
      step();
      chk("release_phase2", {6'd0, phase}, 9'd2);

      goto0();
      //       tag        op    z     rd     wr     ir     ac     pc     inc    de
      run_seq("add",  3'd2, 1'b0, 8'hEE, 8'h00, 8'h0C, 8'h80, 8'h00, 8'h10, 8'h00);
      run_seq("lda",  3'd5, 1'b1, 8'hEE, 8'h00, 8'h0C, 8'h80, 8'h00, 8'h10, 8'h00);
      run_seq("sto",  3'd6, 1'b0, 8'h0E, 8'h80, 8'h0C, 8'h00, 8'h00, 8'h10, 8'hC0);
      run_seq("skz1", 3'd1, 1'b1, 8'h0E, 8'h00, 8'h0C, 8'h00, 8'h00, 8'h50, 8'h00);
      run_seq("skz0", 3'd1, 1'b0, 8'h0E, 8'h00, 8'h0C, 8'h00, 8'h00, 8'h10, 8'h00);
      run_seq("jmp",  3'd7, 1'b0, 8'h0E, 8'h00, 8'h0C, 8'h00, 8'hC0, 8'h90, 8'h00);

      // Opcode change mid-phase affects outputs immediately (phase 6).
      opcode = 3'd2;
      for (int i = 0; i < 6; i++) step();
      chk("midphase_ph6", {6'd0, phase}, 9'd6);
      chk("midphase_add", outs(), 9'b0_1000_0000);
      opcode = 3'd6;
      #1;
      chk("midphase_sto", outs(), 9'b0_0000_0010);
      step();
      step();

      // HLT: halt asserted at phase 4, then sticky with phase frozen.
      goto0();
      opcode = 3'd0;
      for (int i = 0; i < 4; i++) step();
      chk("hlt_ph4", {6'd0, phase}, 9'd4);
      chk("hlt_ph4_outs", outs(), 9'b0_0000_0101);
      for (int i = 0; i < 10; i++) begin
         step();
         chk($sformatf("halted_phase_%0d", i), {6'd0, phase}, 9'd4);
         chk($sformatf("halted_outs_%0d", i), outs(), 9'b0_0000_0001);
      end
      opcode = 3'd2;
      #1;
      chk("halted_opchange_outs", outs(), 9'b0_0000_0001);
      #2;
      rst = 1'b1;
      #1;
      chk("hlt_rst_phase", {6'd0, phase}, 9'd0);
      chk("hlt_rst_outs", outs(), 9'b1_0000_0000);
      step();
      rst = 1'b0;
      step();
      chk("hlt_release_phase1", {6'd0, phase}, 9'd1);

`ifdef CTRL_STALL_EN
      goto0();
      opcode = 3'd2;
      step();
      step();
      chk("stall_at_ph2", {6'd0, phase}, 9'd2);
      stall = 1'b1;
      #1;
      chk("stall_outs", outs(), 9'b1_1000_0000);
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("stall_phase_%0d", i), {6'd0, phase}, 9'd2);
         chk($sformatf("stall_outs_%0d", i), outs(), 9'b1_1000_0000);
      end
      stall = 1'b0;
      #1;
      chk("unstall_outs", outs(), 9'b1_1010_0000);
      step();
      chk("unstall_phase3", {6'd0, phase}, 9'd3);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/ctrl_sequencer.md
Name: ctrl_sequencer

Overview:
- Eight-phase instruction sequencer for the small accumulator CPU built from the lab blocks.
- Sits directly upstream of the address multiplexer and drives its select, steering instruction address (PC) vs operand address (IR) into memory.
- Also generates memory read/write, IR/AC/PC load strobes, PC increment, data-bus enable and halt, from a free-running phase counter decoded against the current 3-bit opcode and the ALU zero flag.

Parameters:
- SEL_ACTIVE, 1'b1, level of `sel` that selects the PC address; `sel` equals ~SEL_ACTIVE when the IR address is selected.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous reset, active-high
- opcode  input  3  instruction opcode from IR; sampled combinationally
- zero  input  1  accumulator-is-zero flag
- sel  output  1  address mux select; SEL_ACTIVE = PC address
- mem_rd  output  1  memory read enable
- mem_wr  output  1  memory write strobe
- load_ir  output  1  instruction register load
- load_ac  output  1  accumulator load
- load_pc  output  1  program counter load (jump)
- inc_pc  output  1  program counter increment
- data_e  output  1  accumulator drives data bus
- halt  output  1  CPU halted, sticky
- phase  output  3  current phase, for debug/bench

Behaviour:
- Reset is asynchronous and active-high: phase=0, halted=0.
- While in reset, outputs decode from phase 0: sel=SEL_ACTIVE, all other outputs 0.
- Phase register increments by 1 each clk, wrapping 7->0.
- Opcodes: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
- ALUOP = opcode in {ADD, AND, XOR, LDA}.
- Outputs are combinational decode of the registered phase, opcode and zero. Zero latency from the phase register; no output registered.
- Phase 0 INST_ADDR: sel=SEL_ACTIVE.
- Phase 1 INST_FETCH: sel=SEL_ACTIVE, mem_rd=1.
- Phase 2 INST_LOAD: sel=SEL_ACTIVE, mem_rd=1, load_ir=1.
- Phase 3 IDLE: sel=SEL_ACTIVE, mem_rd=1, load_ir=1.
- Phase 4 OP_ADDR: inc_pc=1, halt=(opcode==HLT).
- Phase 5 OP_FETCH: mem_rd=ALUOP.
- Phase 6 ALU_OP:
  - mem_rd=ALUOP
  - inc_pc=(opcode==SKZ && zero)
  - load_pc=(opcode==JMP)
  - data_e=(opcode==STO)
- Phase 7 STORE:
  - mem_rd=ALUOP
  - load_ac=ALUOP
  - load_pc=(opcode==JMP)
  - inc_pc=(opcode==JMP)
  - mem_wr=(opcode==STO)
  - data_e=(opcode==STO)
- In phases 4-7, sel = ~SEL_ACTIVE.
- Halt is sticky:
  - On the clk edge leaving phase 4 with opcode==HLT, halted<=1 and phase stays at 4.
  - While halted: phase frozen at 4, halt=1, every other output 0 (inc_pc suppressed), sel=~SEL_ACTIVE.
  - Only rst clears halted.
- Opcode and zero changes mid-phase affect outputs immediately. Phase sequencing is independent of opcode except for HLT.
- rst asserted mid-cycle forces phase 0 without waiting for clk. On the first clk after rst deassert, phase advances 0->1.
- Exactly one of load_pc/inc_pc semantics is used downstream: the PC gives load_pc priority when both are 1.

Optional Feature:
- Macro CTRL_STALL_EN adds input port `stall` (1 bit).
- With CTRL_STALL_EN defined:
  - stall=1 holds phase (no increment) and forces mem_wr, load_ir, load_ac, load_pc and inc_pc to 0.
  - sel, mem_rd and data_e keep their phase decode.
  - A HLT transition is deferred until stall=0.
- Without the macro: no `stall` port, and the phase counter advances every clk.

Test Plan:
- Reset: rst=1 asynchronously mid-phase 5 -> phase=0 immediately, sel=SEL_ACTIVE, all strobes 0, halt=0. Release rst -> phase 1,2,... on successive clks.
- ADD sequence, opcode=2 held 8 clks -> mem_rd=1 in phases 1,2,3,5,6,7; load_ir=1 in phases 2,3; inc_pc=1 in phase 4 only; load_ac=1 in phase 7 only; mem_wr=0 throughout.
- STO, opcode=6 -> data_e=1 in phases 6,7; mem_wr=1 in phase 7 only; mem_rd=0 in phases 5-7.
- SKZ, opcode=1: zero=1 -> inc_pc=1 in phases 4 and 6. zero=0 -> inc_pc=1 in phase 4 only.
- JMP, opcode=7 -> load_pc=1 in phases 6,7; inc_pc=1 in phases 4,7.
- HLT, opcode=0 -> halt=1 at phase 4; phase stays 4 for 10 further clks with halt=1 and inc_pc=0. Pulse rst -> phase=0, halt=0.
- (CTRL_STALL_EN) stall=1 for 3 clks at phase 2 -> phase stays 2 and load_ir=0 during the stall. On the stall=0 cycle, load_ir=1, then phase 3.
